// File: rtl/paj7620_gesture_poller.sv
// Periodically reads the PAJ7620 gesture flag register over I2C and hands every
// nonzero result to the UART transmitter as a one-cycle Data_Available_o strobe.
module paj7620_gesture_poller #(
    parameter int unsigned I2C_DIV_P     = 125,
    parameter int unsigned POLL_CYCLES_P = 5_000_000,
    parameter logic [6:0]  DEV_ADDR_P    = 7'h73,
    parameter logic [7:0]  REG_ADDR_P    = 8'h43
) (
    input  logic       Clk_i,
    input  logic       Reset_i,
    input  logic       Enable_i,
    output logic       Scl_o,
    inout  wire        Sda_io,
    output logic [7:0] Data_o,
    output logic       Data_Available_o,
    output logic       Busy_o,
    output logic       Nack_o
);

    localparam int DIV_W  = (I2C_DIV_P > 1) ? $clog2(I2C_DIV_P) : 1;
    localparam int WAIT_W = (POLL_CYCLES_P > 1) ? $clog2(POLL_CYCLES_P) : 1;
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(I2C_DIV_P - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(POLL_CYCLES_P - 1);

    typedef enum logic [3:0] {
        IDLE, WAIT, START, WR_BYTE, WR_ACK, RSTART, RD_BYTE, RD_NACK, STOP
    } state_t;

    state_t            state_q, state_d;
    logic [DIV_W-1:0]  divCnt_q, divCnt_d;
    logic [WAIT_W-1:0] waitCnt_q, waitCnt_d;
    logic [1:0]        qCnt_q, qCnt_d;
    logic [2:0]        bitCnt_q, bitCnt_d;
    logic [1:0]        byteIdx_q, byteIdx_d;
    logic              scl_q, scl_d;
    logic              sdaLow_q, sdaLow_d;
    logic [7:0]        rxShift_q, rxShift_d;
    logic              ackErr_q, ackErr_d;
    logic              gotByte_q, gotByte_d;
    logic [7:0]        data_q, data_d;
    logic              dataAvail_q, dataAvail_d;
    logic              nack_q, nack_d;

    logic       busy;
    logic       tick;
    logic [7:0] wrByte;
    logic       txBit;

    assign busy  = (state_q != IDLE) && (state_q != WAIT);
    assign tick  = busy && (divCnt_q == DIV_LAST);
    assign txBit = wrByte[~bitCnt_q];

    always_comb begin
        case (byteIdx_q)
            2'd0:    wrByte = {DEV_ADDR_P, 1'b0};
            2'd1:    wrByte = REG_ADDR_P;
            default: wrByte = {DEV_ADDR_P, 1'b1};
        endcase
    end

    always_ff @(posedge Clk_i or posedge Reset_i) begin
        if (Reset_i) begin
            state_q     <= IDLE;
            divCnt_q    <= '0;
            waitCnt_q   <= '0;
            qCnt_q      <= '0;
            bitCnt_q    <= '0;
            byteIdx_q   <= '0;
            scl_q       <= 1'b1;
            sdaLow_q    <= 1'b0;
            rxShift_q   <= '0;
            ackErr_q    <= 1'b0;
            gotByte_q   <= 1'b0;
            data_q      <= '0;
            dataAvail_q <= 1'b0;
            nack_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            divCnt_q    <= divCnt_d;
            waitCnt_q   <= waitCnt_d;
            qCnt_q      <= qCnt_d;
            bitCnt_q    <= bitCnt_d;
            byteIdx_q   <= byteIdx_d;
            scl_q       <= scl_d;
            sdaLow_q    <= sdaLow_d;
            rxShift_q   <= rxShift_d;
            ackErr_q    <= ackErr_d;
            gotByte_q   <= gotByte_d;
            data_q      <= data_d;
            dataAvail_q <= dataAvail_d;
            nack_q      <= nack_d;
        end
    end

    // Each bit is four quarters: q0 sets SDA, q1 raises SCL, q2 samples, q3 drops SCL
    // and decides the next state. STOP keeps SCL high so the bus ends idle.
    always_comb begin
        state_d     = state_q;
        divCnt_d    = divCnt_q;
        waitCnt_d   = waitCnt_q;
        qCnt_d      = qCnt_q;
        bitCnt_d    = bitCnt_q;
        byteIdx_d   = byteIdx_q;
        scl_d       = scl_q;
        sdaLow_d    = sdaLow_q;
        rxShift_d   = rxShift_q;
        ackErr_d    = ackErr_q;
        gotByte_d   = gotByte_q;
        data_d      = data_q;
        dataAvail_d = 1'b0;
        nack_d      = 1'b0;

        case (state_q)
            IDLE: begin
                waitCnt_d = '0;
                scl_d     = 1'b1;
                sdaLow_d  = 1'b0;
                if (Enable_i) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (!Enable_i) begin
                    state_d   = IDLE;
                    waitCnt_d = '0;
                end else if (waitCnt_q == WAIT_LAST) begin
                    state_d   = START;
                    waitCnt_d = '0;
                    divCnt_d  = '0;
                    qCnt_d    = '0;
                    ackErr_d  = 1'b0;
                    gotByte_d = 1'b0;
                end else begin
                    waitCnt_d = waitCnt_q + 1'b1;
                end
            end
            default: begin
                divCnt_d = tick ? '0 : divCnt_q + 1'b1;
                if (tick) begin
                    qCnt_d = qCnt_q + 2'd1;
                    case (qCnt_q)
                        2'd0: begin
                            case (state_q)
                                WR_BYTE: sdaLow_d = ~txBit;
                                STOP:    sdaLow_d = 1'b1;
                                default: sdaLow_d = 1'b0;
                            endcase
                        end
                        2'd1: begin
                            scl_d = 1'b1;
                        end
                        2'd2: begin
                            case (state_q)
                                START, RSTART: sdaLow_d = 1'b1;
                                WR_ACK: begin
                                    if (Sda_io) begin
                                        ackErr_d = 1'b1;
                                        nack_d   = 1'b1;
                                    end
                                end
                                RD_BYTE: rxShift_d = {rxShift_q[6:0], Sda_io};
                                STOP:    sdaLow_d  = 1'b0;
                                default: ;
                            endcase
                        end
                        default: begin
                            if (state_q != STOP) begin
                                scl_d = 1'b0;
                            end
                            case (state_q)
                                START: begin
                                    state_d   = WR_BYTE;
                                    bitCnt_d  = '0;
                                    byteIdx_d = 2'd0;
                                end
                                WR_BYTE: begin
                                    bitCnt_d = bitCnt_q + 3'd1;
                                    if (bitCnt_q == 3'd7) begin
                                        state_d = WR_ACK;
                                    end
                                end
                                WR_ACK: begin
                                    if (ackErr_q) begin
                                        state_d = STOP;
                                    end else if (byteIdx_q == 2'd0) begin
                                        state_d   = WR_BYTE;
                                        byteIdx_d = 2'd1;
                                    end else if (byteIdx_q == 2'd1) begin
                                        state_d   = RSTART;
                                        byteIdx_d = 2'd2;
                                    end else begin
                                        state_d = RD_BYTE;
                                    end
                                end
                                RSTART: begin
                                    state_d = WR_BYTE;
                                end
                                RD_BYTE: begin
                                    bitCnt_d = bitCnt_q + 3'd1;
                                    if (bitCnt_q == 3'd7) begin
                                        state_d = RD_NACK;
                                    end
                                end
                                RD_NACK: begin
                                    state_d   = STOP;
                                    gotByte_d = 1'b1;
                                end
                                STOP: begin
                                    state_d   = Enable_i ? WAIT : IDLE;
                                    waitCnt_d = '0;
                                    // A zero byte means "no gesture" and is not forwarded.
                                    if (gotByte_q && (rxShift_q != 8'h00)) begin
                                        data_d      = rxShift_q;
                                        dataAvail_d = 1'b1;
                                    end
                                end
                                default: ;
                            endcase
                        end
                    endcase
                end
            end
        endcase
    end

    assign Sda_io           = sdaLow_q ? 1'b0 : 1'bz;
    assign Scl_o            = scl_q;
    assign Data_o           = data_q;
    assign Data_Available_o = dataAvail_q;
    assign Busy_o           = busy;
    assign Nack_o           = nack_q;

endmodule

// File: tb/tb_paj7620_gesture_poller.sv
// Bench for paj7620_gesture_poller: a bit-level I2C slave model logs bus events
// and reported bytes, which are scored against queues of expected results.
module tb_paj7620_gesture_poller;

    localparam int          DIV  = 4;
    localparam int          POLL = 100;
    localparam logic [6:0]  DEV  = 7'h73;
    localparam logic [7:0]  REG  = 8'h43;
    localparam logic [11:0] EV_S    = 12'h100;
    localparam logic [11:0] EV_SR   = 12'h101;
    localparam logic [11:0] EV_P    = 12'h102;
    localparam logic [11:0] EV_NONE = 12'hFFF;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       scl;
    wire        sdaBus;
    logic [7:0] dataOut;
    logic       dav;
    logic       busy;
    logic       nack;
    logic       slaveOe = 1'b0;

    assign sdaBus = slaveOe ? 1'b0 : 1'bz;
    pullup (sdaBus);

    paj7620_gesture_poller #(
        .I2C_DIV_P    (DIV),
        .POLL_CYCLES_P(POLL),
        .DEV_ADDR_P   (DEV),
        .REG_ADDR_P   (REG)
    ) dut (
        .Clk_i           (clk),
        .Reset_i         (rst),
        .Enable_i        (enable),
        .Scl_o           (scl),
        .Sda_io          (sdaBus),
        .Data_o          (dataOut),
        .Data_Available_o(dav),
        .Busy_o          (busy),
        .Nack_o          (nack)
    );

    always #5 clk = ~clk;

    int          checkCount = 0;
    int          passCount  = 0;
    int          davCount   = 0;
    int          nackCount  = 0;
    int          cyc        = 0;
    int          lastRise   = -1;
    int          sclRises   = 0;
    logic [11:0] expBus[$];
    logic [7:0]  expData[$];

    logic [7:0]  rdData   = 8'h00;
    logic        nackMode = 1'b0;
    logic        checkBus = 1'b1;
    logic        inFrame  = 1'b0;
    logic        rdPhase  = 1'b0;
    logic        rdAddr   = 1'b0;
    logic [7:0]  shift    = 8'h00;
    int          bitPos   = -1;
    int          byteNum  = 0;

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end else begin
            passCount++;
        end
    endtask

    task automatic applyStimulus(input logic [7:0] rd, input logic slaveNacks);
        rdData   = rd;
        nackMode = slaveNacks;
        expBus.push_back(EV_S);
        expBus.push_back({4'h0, DEV, 1'b0});
        if (slaveNacks) begin
            expBus.push_back(EV_P);
        end else begin
            expBus.push_back({4'h0, REG});
            expBus.push_back(EV_SR);
            expBus.push_back({4'h0, DEV, 1'b1});
            expBus.push_back({4'h0, rd});
            expBus.push_back(EV_P);
            if (rd != 8'h00) begin
                expData.push_back(rd);
            end
        end
    endtask

    task automatic logEvent(input logic [11:0] evt);
        if (checkBus) begin
            if (expBus.size() > 0) begin
                checkOutput("busEvent", {20'h0, evt}, {20'h0, expBus.pop_front()});
            end else begin
                checkOutput("busUnexpected", {20'h0, evt}, {20'h0, EV_NONE});
            end
        end
    endtask

    task automatic resetSlave();
        slaveOe = 1'b0;
        inFrame = 1'b0;
        rdPhase = 1'b0;
        bitPos  = -1;
    endtask

    task automatic waitBusy(input string tag, input logic level, input int budget);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy !== level && n < budget);
        checkOutput(tag, {31'h0, busy}, {31'h0, level});
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // I2C slave: decodes START/STOP, clocks bits on SCL edges, ACKs or NACKs, serves rdData.
    initial begin
        logic c, s, prevScl, prevSda;
        prevScl = 1'b1;
        prevSda = 1'b1;
        forever begin
            @(negedge clk);
            c = scl;
            s = sdaBus;
            if (c && prevScl && prevSda && !s) begin
                logEvent(inFrame ? EV_SR : EV_S);
                inFrame = 1'b1;
                bitPos  = -1;
                shift   = 8'h00;
                byteNum = 0;
                rdPhase = 1'b0;
                rdAddr  = 1'b0;
            end else if (c && prevScl && !prevSda && s) begin
                logEvent(EV_P);
                resetSlave();
            end else if (c && !prevScl) begin
                sclRises++;
                if (busy) begin
                    if (lastRise >= 0) begin
                        checkOutput("sclPeriod", cyc - lastRise, 4 * DIV);
                    end
                    lastRise = cyc;
                end
                if (bitPos >= 0 && bitPos < 8) begin
                    shift = {shift[6:0], s};
                end
            end else if (!c && prevScl && inFrame) begin
                bitPos++;
                if (bitPos == 8) begin
                    logEvent({4'h0, shift});
                    if (rdPhase) begin
                        slaveOe = 1'b0;
                    end else begin
                        slaveOe = !nackMode;
                        if (byteNum == 0) rdAddr = shift[0];
                    end
                end else if (bitPos == 9) begin
                    slaveOe = 1'b0;
                    bitPos  = 0;
                    if (byteNum == 0 && rdAddr && !nackMode && !rdPhase) begin
                        rdPhase = 1'b1;
                        slaveOe = !rdData[7];
                    end else begin
                        rdPhase = 1'b0;
                    end
                    byteNum++;
                end else if (rdPhase && bitPos >= 1 && bitPos <= 7) begin
                    slaveOe = !rdData[7 - bitPos];
                end
            end
            if (!busy) lastRise = -1;
            prevScl = c;
            prevSda = s;
        end
    end

    initial begin
        logic prevDav, prevNack;
        prevDav  = 1'b0;
        prevNack = 1'b0;
        forever begin
            @(negedge clk);
            if (dav) begin
                davCount++;
                checkOutput("davWithNack", {31'h0, nack}, 32'h0);
                checkOutput("davWidth", {31'h0, prevDav}, 32'h0);
                if (expData.size() > 0) begin
                    checkOutput("davData", {24'h0, dataOut}, {24'h0, expData.pop_front()});
                end else begin
                    checkOutput("davUnexpected", {24'h0, dataOut}, {20'h0, EV_NONE});
                end
            end
            if (nack) begin
                nackCount++;
                checkOutput("nackWidth", {31'h0, prevNack}, 32'h0);
            end
            prevDav  = dav;
            prevNack = nack;
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int fallCyc;
        int relCyc;
        int n;
        int startRises;
        int busySeen;

        rst    = 1'b1;
        enable = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rstScl",  {31'h0, scl},    32'h1);
        checkOutput("rstSda",  {31'h0, sdaBus}, 32'h1);
        checkOutput("rstBusy", {31'h0, busy},   32'h0);
        checkOutput("rstData", {24'h0, dataOut}, 32'h0);
        checkOutput("rstDav",  {31'h0, dav},    32'h0);
        checkOutput("rstNack", {31'h0, nack},   32'h0);

        // Gesture 0x04 read and reported once.
        applyStimulus(8'h04, 1'b0);
        rst    = 1'b0;
        enable = 1'b1;
        relCyc = cyc;
        waitBusy("startB", 1'b1, 300);
        checkOutput("firstStartGap", cyc - relCyc, POLL + 1);
        waitBusy("endB", 1'b0, 1500);
        fallCyc = cyc;
        repeat (3) @(negedge clk);
        checkOutput("dataB", {24'h0, dataOut}, 32'h04);
        checkOutput("davCountB", davCount, 1);

        // Zero byte: full transaction, nothing reported.
        applyStimulus(8'h00, 1'b0);
        waitBusy("startC", 1'b1, 300);
        checkOutput("pollGapC", cyc - fallCyc, POLL);
        waitBusy("endC", 1'b0, 1500);
        fallCyc = cyc;
        repeat (3) @(negedge clk);
        checkOutput("dataC", {24'h0, dataOut}, 32'h04);
        checkOutput("davCountC", davCount, 1);

        // Slave NACKs the address byte.
        applyStimulus(8'h55, 1'b1);
        waitBusy("startD", 1'b1, 300);
        checkOutput("pollGapD", cyc - fallCyc, POLL);
        waitBusy("endD", 1'b0, 1500);
        fallCyc = cyc;
        repeat (3) @(negedge clk);
        checkOutput("nackCountD", nackCount, 1);
        checkOutput("dataD", {24'h0, dataOut}, 32'h04);
        checkOutput("davCountD", davCount, 1);

        // Enable dropped during the read byte: still reported, then idle.
        applyStimulus(8'h80, 1'b0);
        waitBusy("startE", 1'b1, 300);
        checkOutput("pollGapE", cyc - fallCyc, POLL);
        n = 0;
        while (!rdPhase && n < 1500) begin
            @(negedge clk);
            n++;
        end
        checkOutput("reachedReadE", {31'h0, rdPhase}, 32'h1);
        enable = 1'b0;
        waitBusy("endE", 1'b0, 1500);
        repeat (3) @(negedge clk);
        checkOutput("dataE", {24'h0, dataOut}, 32'h80);
        checkOutput("davCountE", davCount, 2);
        busySeen = 0;
        repeat (300) begin
            @(negedge clk);
            if (busy) busySeen++;
        end
        checkOutput("noRestartE", busySeen, 0);
        checkOutput("idleSclE", {31'h0, scl}, 32'h1);
        checkOutput("idleSdaE", {31'h0, sdaBus}, 32'h1);

        // Reset in the middle of the first write byte, with SCL and SDA both low.
        checkBus = 1'b0;
        enable   = 1'b1;
        waitBusy("startF", 1'b1, 300);
        startRises = sclRises;
        n = 0;
        while (sclRises - startRises < 3 && n < 500) begin
            @(negedge clk);
            n++;
        end
        repeat (14) @(negedge clk);
        checkOutput("preRstSclLow", {31'h0, scl}, 32'h0);
        rst = 1'b1;
        #1;
        checkOutput("midRstScl",  {31'h0, scl},     32'h1);
        checkOutput("midRstSda",  {31'h0, sdaBus},  32'h1);
        checkOutput("midRstBusy", {31'h0, busy},    32'h0);
        checkOutput("midRstData", {24'h0, dataOut}, 32'h0);
        checkOutput("midRstDav",  {31'h0, dav},     32'h0);
        repeat (3) @(negedge clk);
        resetSlave();
        expBus.delete();
        checkBus = 1'b1;
        applyStimulus(8'h33, 1'b0);
        rst    = 1'b0;
        relCyc = cyc;
        waitBusy("startG", 1'b1, 300);
        checkOutput("postRstGap", cyc - relCyc, POLL + 1);
        waitBusy("endG", 1'b0, 1500);
        repeat (3) @(negedge clk);
        checkOutput("dataG", {24'h0, dataOut}, 32'h33);
        checkOutput("davCountG", davCount, 3);
        checkOutput("nackCountG", nackCount, 1);

        checkOutput("expBusEmpty", expBus.size(), 0);
        checkOutput("expDataEmpty", expData.size(), 0);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/paj7620_gesture_poller.md
PAJ7620_GESTURE_POLLER -- requirements
Module: paj7620_gesture_poller

Interface
REQ-001 SHALL have parameter I2C_DIV_P, default 125, Clk_i cycles per I2C quarter-bit (50 MHz -> 100 kHz SCL).
REQ-002 SHALL have parameter POLL_CYCLES_P, default 5_000_000, idle Clk_i cycles between end of STOP and next START (100 ms).
REQ-003 SHALL have parameter DEV_ADDR_P, default 7'h73, sensor 7-bit I2C address.
REQ-004 SHALL have parameter REG_ADDR_P, default 8'h43, gesture flag register address.
REQ-005 SHALL have port Clk_i, input, 1, system clock; single clock domain, all logic on rising edge.
REQ-006 SHALL have port Reset_i, input, 1, reset; asynchronous, active-high.
REQ-007 SHALL have port Enable_i, input, 1, high permits polling; sensor init is complete upstream.
REQ-008 SHALL have port Scl_o, output, 1, I2C clock, push-pull; no clock stretching supported.
REQ-009 SHALL have port Sda_io, inout, 1, I2C data, open-drain: drives 0 or Z only.
REQ-010 SHALL have port Data_o, output, 8, last nonzero gesture byte; feeds UART transmitter Data_i.
REQ-011 SHALL have port Data_Available_o, output, 1, one-cycle pulse when Data_o updates; feeds UART Data_Available_i.
REQ-012 SHALL have port Busy_o, output, 1, high from START to end of STOP.
REQ-013 SHALL have port Nack_o, output, 1, one-cycle pulse on any missing slave ACK.

Function
REQ-014 SHALL generate a quarter tick every I2C_DIV_P cycles while Busy_o high; each bit = 4 ticks: q0 SCL low + SDA update, q1 SCL rise, q2 SDA sample, q3 SCL fall.
REQ-015 SHALL use FSM states IDLE, WAIT, START, WR_BYTE, WR_ACK, RSTART, RD_BYTE, RD_NACK, STOP.
REQ-016 IDLE -> WAIT when Enable_i high; WAIT counts POLL_CYCLES_P then -> START; count restarts from 0 on each WAIT entry.
REQ-017 Transaction SHALL be: START, byte {DEV_ADDR_P,0}, ACK, byte REG_ADDR_P, ACK, RSTART, byte {DEV_ADDR_P,1}, ACK, RD_BYTE, master NACK, STOP.
REQ-018 START/RSTART: SDA falls while SCL high; STOP: SDA rises while SCL high; bus left with SCL=1, SDA=Z.
REQ-019 Bytes SHALL be shifted MSB first; 3-bit bit counter; 2-bit byte index selects write byte.
REQ-020 WR_ACK samples Sda_io at q2; value 1 -> Nack_o pulse, go directly to STOP, no data update.
REQ-021 RD_BYTE SHALL release SDA and sample 8 bits at q2; RD_NACK releases SDA for 1 bit.
REQ-022 After STOP: read byte != 8'h00 -> Data_o <= byte and Data_Available_o high exactly one cycle; byte == 8'h00 -> no pulse, Data_o held.
REQ-023 Nonzero non-one-hot bytes SHALL be reported unchanged (downstream handles default).
REQ-024 After STOP -> WAIT if Enable_i high, else IDLE.
REQ-025 Enable_i falling mid-transaction SHALL NOT abort; transaction completes, then IDLE.
REQ-026 Enable_i falling in WAIT -> IDLE next cycle, counter cleared.
REQ-027 Data_Available_o and Nack_o SHALL never assert in the same cycle.

Reset
REQ-028 Reset_i high SHALL immediately force: state IDLE, Scl_o=1, Sda_io=Z, Data_o=8'h00, Data_Available_o=0, Busy_o=0, Nack_o=0, all counters 0.
REQ-029 Reset mid-transaction SHALL release bus without STOP; after release, first START occurs only after full POLL_CYCLES_P in WAIT.

Verification
REQ-030 Bench SHALL cover: I2C slave model ACKs all, returns 8'h04 -> bus shows E6,43,Sr,E7, Data_o=8'h04, one Data_Available_o pulse after STOP.
REQ-031 Bench SHALL cover: slave returns 8'h00 -> full transaction, no Data_Available_o pulse, Data_o keeps previous 8'h04.
REQ-032 Bench SHALL cover: slave NACKs address byte -> Nack_o one pulse, STOP follows, Data_o unchanged, next poll after POLL_CYCLES_P.
REQ-033 Bench SHALL cover: POLL_CYCLES_P=100, I2C_DIV_P=4 -> SCL period 16 cycles, START exactly 100 cycles after STOP completion.
REQ-034 Bench SHALL cover: Enable_i dropped during RD_BYTE -> byte 8'h80 still reported, then IDLE, no further START.
REQ-035 Bench SHALL cover: Reset_i asserted mid-WR_BYTE -> same cycle Scl_o=1, Sda_io=Z, Busy_o=0, Data_o=8'h00.
